// File: rtl/conway_driver.sv
// conway_driver: row-stream pattern loader and generation pacer for the 8x8 Life grid.
// Optional still-life auto-halt is built when CONWAY_DRIVER_STABLE_STOP_EN is defined.
module conway_driver #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int STEP_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [COLS-1:0]      row_data,
  input  logic                 row_valid,
  output logic                 row_ready,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 step,
  input  logic                 clear,
  input  logic [ROWS*COLS-1:0] current_state,
  input  logic [ROWS*COLS-1:0] next_state,
  output logic [ROWS*COLS-1:0] initial_state,
  output logic                 clk_en,
  output logic                 load_run,
  output logic                 running,
  output logic [15:0]          gen_count,
  output logic                 stable
);

  localparam int              RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
  localparam logic [23:0]     PRESC_TC = 24'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PRIME = 3'd2,
    ST_HALT  = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

  state_t                 state_r, state_nxt;
  logic [RW-1:0]          row_r, row_nxt;
  logic [ROWS*COLS-1:0]   init_r, init_nxt;
  logic [23:0]            presc_r, presc_nxt;
  logic                   clk_en_r, clk_en_nxt;
  logic                   load_run_r, load_run_nxt;
  logic                   running_r;
  logic [15:0]            gen_r, gen_nxt;
  logic                   beat;
  logic                   still;
  logic                   still_halt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign row_ready     = (state_r == ST_IDLE) || (state_r == ST_LOAD);
  assign beat          = row_valid && row_ready;
  assign initial_state = init_r;
  assign clk_en        = clk_en_r;
  assign load_run      = load_run_r;
  assign running       = running_r;
  assign gen_count     = gen_r;

`ifdef CONWAY_DRIVER_STABLE_STOP_EN
  logic stable_r;

  assign still  = (next_state == current_state);
  assign stable = stable_r;

  // Still-life flag: set by the RUN step that detected it, cleared by clear/start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_r <= 1'b0;
    end else if (clear) begin
      stable_r <= 1'b0;
    end else if (still_halt) begin
      stable_r <= 1'b1;
    end else if (start) begin
      stable_r <= 1'b0;
    end else begin
      stable_r <= stable_r;
    end
  end
`else
  logic unused_status;

  assign still         = 1'b0;
  assign stable        = 1'b0;
  assign unused_status = ^{current_state, next_state, still_halt};
`endif

  // Next-state, pattern assembly, prescaler and step-pulse generation
  always_comb begin
    state_nxt    = state_r;
    row_nxt      = row_r;
    init_nxt     = init_r;
    presc_nxt    = presc_r;
    clk_en_nxt   = 1'b0;
    load_run_nxt = load_run_r;
    gen_nxt      = gen_r;
    still_halt   = 1'b0;
    if (clear) begin
      state_nxt    = ST_IDLE;
      row_nxt      = '0;
      init_nxt     = '0;
      presc_nxt    = 24'd0;
      load_run_nxt = 1'b0;
      gen_nxt      = 16'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_LOAD: begin
          if (beat) begin
            for (int r = 0; r < ROWS; r++) begin
              if (row_r == RW'(r)) begin
                init_nxt[r*COLS +: COLS] = row_data;
              end else begin
                init_nxt[r*COLS +: COLS] = init_r[r*COLS +: COLS];
              end
            end
            if (row_r == ROW_LAST) begin
              // The grid latches the pattern during the single PRIME cycle
              state_nxt    = ST_PRIME;
              row_nxt      = '0;
              clk_en_nxt   = 1'b1;
              load_run_nxt = 1'b0;
              gen_nxt      = 16'd0;
            end else begin
              state_nxt = ST_LOAD;
              row_nxt   = row_r + RW'(1);
            end
          end else begin
            state_nxt = state_r;
          end
        end
        ST_PRIME: begin
          state_nxt = ST_HALT;
        end
        ST_HALT: begin
          if (stop) begin
            state_nxt = ST_HALT;
          end else if (start) begin
            state_nxt    = ST_RUN;
            presc_nxt    = 24'd0;
            load_run_nxt = 1'b1;
          end else if (step) begin
            clk_en_nxt   = 1'b1;
            load_run_nxt = 1'b1;
            gen_nxt      = sat_inc(gen_r);
          end else begin
            state_nxt = ST_HALT;
          end
        end
        ST_RUN: begin
          load_run_nxt = 1'b1;
          if (stop) begin
            state_nxt = ST_HALT;
            presc_nxt = 24'd0;
          end else if (presc_r == PRESC_TC) begin
            presc_nxt  = 24'd0;
            clk_en_nxt = 1'b1;
            gen_nxt    = sat_inc(gen_r);
            if (still) begin
              state_nxt  = ST_HALT;
              still_halt = 1'b1;
            end else begin
              state_nxt = ST_RUN;
            end
          end else begin
            presc_nxt = presc_r + 24'd1;
          end
        end
        default: begin
          state_nxt    = ST_IDLE;
          row_nxt      = '0;
          init_nxt     = '0;
          presc_nxt    = 24'd0;
          load_run_nxt = 1'b0;
          gen_nxt      = 16'd0;
        end
      endcase
    end
  end

  // State and output registers; clk_en leaves straight from a flop for the clock gate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      row_r      <= '0;
      init_r     <= '0;
      presc_r    <= 24'd0;
      clk_en_r   <= 1'b0;
      load_run_r <= 1'b0;
      running_r  <= 1'b0;
      gen_r      <= 16'd0;
    end else begin
      state_r    <= state_nxt;
      row_r      <= row_nxt;
      init_r     <= init_nxt;
      presc_r    <= presc_nxt;
      clk_en_r   <= clk_en_nxt;
      load_run_r <= load_run_nxt;
      running_r  <= (state_nxt == ST_RUN);
      gen_r      <= gen_nxt;
    end
  end

endmodule

// File: tb/tb_conway_driver.sv
// Self-checking bench for conway_driver: table-driven row loads with a scoreboard,
// plus hand-written sequences for RUN cadence, priority, clear, still life and async reset.
module tb_conway_driver;

  localparam int ROWS     = 8;
  localparam int COLS     = 8;
  localparam int STEP_DIV = 4;
  localparam logic [63:0] BLOCK = 64'h0000_0018_1800_0000;

  logic        clk;
  logic        reset_n;
  logic [7:0]  row_data;
  logic        row_valid;
  logic        row_ready;
  logic        start, stop, step, clear;
  logic [63:0] current_state, next_state, initial_state;
  logic        clk_en, load_run, running, stable;
  logic [15:0] gen_count;

  conway_driver #(.ROWS(ROWS), .COLS(COLS), .STEP_DIV(STEP_DIV)) dut (
    .clk(clk), .reset_n(reset_n),
    .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
    .start(start), .stop(stop), .step(step), .clear(clear),
    .current_state(current_state), .next_state(next_state),
    .initial_state(initial_state),
    .clk_en(clk_en), .load_run(load_run), .running(running),
    .gen_count(gen_count), .stable(stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [63:0] exp_init;
  } vec_t;

  vec_t        tab[3][ROWS];
  logic [63:0] sb_q[$];
  int          pulse_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_k;
  logic [63:0] acc;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream table p into the DUT; each beat pushes the expected word, popped after the edge.
  task automatic run_load(input int p);
    logic [63:0] exp;
    for (int i = 0; i < ROWS; i++) begin
      row_data  = tab[p][i].data;
      row_valid = 1'b1;
      sb_q.push_back(tab[p][i].exp_init);
      check1("row_ready_load", row_ready, 1'b1);
      tick();
      exp = sb_q.pop_front();
      check64("init_after_beat", initial_state, exp);
    end
    row_valid = 1'b0;
    check1("prime_clk_en", clk_en, 1'b1);
    check1("prime_load_run", load_run, 1'b0);
    check64("prime_gen", 64'(gen_count), 64'd0);
    check1("prime_row_ready", row_ready, 1'b0);
    tick();
    check1("halt_clk_en", clk_en, 1'b0);
    check1("halt_row_ready", row_ready, 1'b0);
    check1("halt_running", running, 1'b0);
  endtask

  initial begin
    for (int p = 0; p < 3; p++) begin
      acc = 64'd0;
      for (int i = 0; i < ROWS; i++) begin
        case (p)
          0:       tab[p][i].data = 8'(1 << i);
          1:       tab[p][i].data = 8'hFF;
          default: tab[p][i].data = (i == 3 || i == 4) ? 8'h18 : 8'h00;
        endcase
        acc[i*COLS +: COLS]   = tab[p][i].data;
        tab[p][i].exp_init    = acc;
      end
    end

    row_data = 8'h00; row_valid = 1'b0;
    start = 1'b0; stop = 1'b0; step = 1'b0; clear = 1'b0;
    current_state = 64'd0; next_state = 64'd1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #10;
    check1("rst_row_ready", row_ready, 1'b1);
    check64("rst_init", initial_state, 64'd0);
    check1("rst_clk_en", clk_en, 1'b0);
    check1("rst_load_run", load_run, 1'b0);
    check1("rst_running", running, 1'b0);
    check64("rst_gen", 64'(gen_count), 64'd0);
    check1("rst_stable", stable, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    // Diagonal load
    run_load(0);
    check64("diag_pattern", initial_state, 64'h8040_2010_0804_0201);

    // Rows offered in HALT are ignored
    row_valid = 1'b1; row_data = 8'hAA;
    tick();
    row_valid = 1'b0;
    check64("halt_rows_ignored", initial_state, 64'h8040_2010_0804_0201);

    // RUN cadence: start at E0, stop sampled at E10 -> pulses at E4, E8 only
    start = 1'b1;
    tick();
    start = 1'b0;
    check1("run_running", running, 1'b1);
    check1("run_load_run", load_run, 1'b1);
    pulse_q.push_back(4);
    pulse_q.push_back(8);
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (clk_en) begin
        exp_k = (pulse_q.size() > 0) ? pulse_q.pop_front() : -1;
        check_int("run_pulse_cycle", k, exp_k);
      end
      step = (k == 1);
      stop = (k == 9);
    end
    step = 1'b0; stop = 1'b0;
    check_int("run_missing_pulses", pulse_q.size(), 0);
    check64("run_gen", 64'(gen_count), 64'd2);
    check1("run_stopped", running, 1'b0);
    check1("run_load_run_halt", load_run, 1'b1);

    // Single step in HALT
    step = 1'b1;
    tick();
    step = 1'b0;
    check1("step_clk_en", clk_en, 1'b1);
    check1("step_load_run", load_run, 1'b1);
    check64("step_gen", 64'(gen_count), 64'd3);
    tick();
    check1("step_clk_en_drop", clk_en, 1'b0);

    // start+stop together: stop wins, no pulses follow
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check1("startstop_running", running, 1'b0);
    for (int k = 0; k < 6; k++) tick();
    check64("startstop_gen", 64'(gen_count), 64'd3);

    // clear, partial load, clear again, idle gap, then full load of 0xFF rows
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check64("clear_init", initial_state, 64'd0);
    check64("clear_gen", 64'(gen_count), 64'd0);
    check1("clear_row_ready", row_ready, 1'b1);
    check1("clear_load_run", load_run, 1'b0);
    row_valid = 1'b1; row_data = 8'h5A;
    for (int k = 0; k < 3; k++) tick();
    row_valid = 1'b0;
    check64("partial_init", initial_state, 64'h0000_0000_005A_5A5A);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check64("partial_discarded", initial_state, 64'd0);
    tick();
    check64("idle_gap", initial_state, 64'd0);
    run_load(1);
    check64("ones_pattern", initial_state, 64'hFFFF_FFFF_FFFF_FFFF);

    // Still life: 2x2 block, grid reports next == current
    clear = 1'b1;
    tick();
    clear = 1'b0;
    current_state = BLOCK; next_state = BLOCK;
    run_load(2);
    check64("block_pattern", initial_state, BLOCK);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    check1("block_first_pulse", clk_en, 1'b1);
    check64("block_gen_pulse", 64'(gen_count), 64'd1);
    tick();
    check64("block_gen", 64'(gen_count), 64'd1);
`ifdef CONWAY_DRIVER_STABLE_STOP_EN
    check1("block_running", running, 1'b0);
    check1("block_stable", stable, 1'b1);
`else
    check1("block_running", running, 1'b1);
    check1("block_stable", stable, 1'b0);
`endif

    // Asynchronous reset while clk_en is high in RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12 && !clk_en; k++) tick();
    check1("pre_reset_clk_en", clk_en, 1'b1);
    reset_n = 1'b0;
    #1;
    check1("arst_clk_en", clk_en, 1'b0);
    check1("arst_load_run", load_run, 1'b0);
    check1("arst_running", running, 1'b0);
    check64("arst_gen", 64'(gen_count), 64'd0);
    check1("arst_stable", stable, 1'b0);
    check64("arst_init", initial_state, 64'd0);
    check1("arst_row_ready", row_ready, 1'b1);
    #20 reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
